p09_paddle_controller: RTL and testbench
========================================

// Module: p09_paddle_controller
// PURPOSE
//  Produces the paddle x position consumed by p09_paddle_painter (its x input) from player buttons.
//  Samples synchronised left/right buttons once per frame, outside the visible area, and ramps speed while held.
//  Clamps x so the whole paddle stays on screen.
//  Sits between the button pads and the painter/ball logic in the breakout top.
// PARAMETERS
//  SCREEN_WIDTH  10'd640  visible width in pixels
//  PADDLE_WIDTH  10'd48   paddle width (8 px segment x 6 segments); X_MAX = SCREEN_WIDTH-PADDLE_WIDTH = 592
//  X_RESET       10'd296  x after reset and on recentre
//  UPDATE_LINE   9'd480   vpos of the frame tick (first non-visible line)
//  SPEED_MIN     3'd1     px/frame on the first frame of a move
//  SPEED_MAX     3'd6     px/frame saturation
//  ACCEL_FRAMES  3'd4     frames per speed step; must be >=2
// PORTS
//  clk           in   1   pixel clock
//  nRst          in   1   asynchronous active-low reset
//  hpos          in   10  current pixel column
//  vpos          in   9   current line
//  btn_left      in   1   raw async button, active high
//  btn_right     in   1   raw async button, active high
//  enable        in   1   game running; low freezes the paddle
//  recentre      in   1   sync level/pulse; request x=X_RESET at next tick
//  x             out  10  paddle left edge, to painter
//  moving        out  1   state != IDLE
//  at_left_edge  out  1   x == 0
//  at_right_edge out  1   x == X_MAX
// BEHAVIOUR
//  Reset: x=X_RESET, state=IDLE, speed=SPEED_MIN, acc_cnt=0, sync FFs=0; moving=0; edge flags decoded from x (both 0).
//  Buttons pass a 2-FF synchroniser; only synchronised values are used.
//  tick = (hpos==0 && vpos==UPDATE_LINE), one clk wide; all registers except sync FFs change only on a tick.
//  Latency: x/state update on the edge that samples tick; x stable for the whole visible frame.
//  Button activity between ticks is ignored (no latching).
//  dir at tick: L if left&!right, R if right&!left, NONE otherwise (both pressed == NONE).
//  Priority at tick: recentre > !enable > dir.
//   recentre: x<=X_RESET, state<=IDLE, speed<=SPEED_MIN, acc_cnt<=0 (regardless of enable).
//   !enable: state<=IDLE, speed<=SPEED_MIN, acc_cnt<=0, x held.
//   NONE: same as !enable.
//  FSM IDLE/MOVE_L/MOVE_R:
//   dir differs from state (IDLE->move or reversal): step=SPEED_MIN; speed<=SPEED_MIN; acc_cnt<=1; state<=MOVE_dir.
//   dir equals state: step=speed; if acc_cnt==ACCEL_FRAMES-1 then acc_cnt<=0, speed<=min(speed+1,SPEED_MAX)
//    else acc_cnt<=acc_cnt+1.
//  Position arithmetic in 11-bit signed/extended form; no wrap:
//   L: x<=(x<step)?0:x-step.  R: x<=(x+step>X_MAX)?X_MAX:x+step.
//  Clamped moves keep state and the ramp running; speed is not reset at the edge.
//  Reset mid-move returns all state to reset values immediately (async).
// STRUCTURE
//  p09_defs.vh: SCREEN_WIDTH, PADDLE_WIDTH, PADDLE_Y, UPDATE_LINE, state encodings (2-bit IDLE=0, MOVE_L=1, MOVE_R=2).
//  Shared with the painter and ball logic.
//  Sub-module p09_sync2: 2-FF synchroniser with async active-low reset, instantiated per button.
// TESTING
//  1 Reset, no buttons, 3 frames -> x=296, moving=0, both edge flags 0; x never changes mid-frame.
//  2 Hold right from reset for 12 ticks -> per-tick steps 1,1,1,1,2,2,2,2,3,3,3,3; x=320; moving=1.
//  3 Hold left from x=5 for 2 ticks -> x=4 then 3; continue until x=0, at_left_edge=1; further ticks hold x at 0.
//  4 Ramp right to speed 3, then press left -> next tick steps 1 left; ramp restarts.
//  5 Both buttons for 2 ticks -> x held, state IDLE; a 100-clk right pulse entirely between ticks -> x unchanged.
//  6 recentre+right at same tick from x=592 -> x=296, state IDLE; nRst low mid-frame while moving -> x=296 at once.

Source files
------------

// File: rtl/p09_paddle_controller_pkg.sv
// Shared breakout constants and paddle FSM encodings used by the paddle controller,
// painter and ball logic.
package p09_paddle_controller_pkg;

  localparam logic [9:0] SCREEN_WIDTH = 10'd640;
  localparam logic [9:0] PADDLE_WIDTH = 10'd48;
  localparam logic [9:0] X_MAX        = SCREEN_WIDTH - PADDLE_WIDTH;
  localparam logic [9:0] X_RESET      = 10'd296;
  localparam logic [8:0] UPDATE_LINE  = 9'd480;
  localparam logic [2:0] SPEED_MIN    = 3'd1;
  localparam logic [2:0] SPEED_MAX    = 3'd6;
  localparam logic [2:0] ACCEL_FRAMES = 3'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMoveL = 2'd1,
    StMoveR = 2'd2
  } state_e;

  // Moves x by step in the given direction, clamped to [0, X_MAX] without wrap.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [2:0] step,
                                        input state_e dir);
    logic [10:0] sum;
    sum = {1'b0, x} + {8'b0, step};
    if (dir == StMoveL) begin
      step_x = (x < {7'b0, step}) ? 10'd0 : x - {7'b0, step};
    end else if (dir == StMoveR) begin
      step_x = (sum > {1'b0, X_MAX}) ? X_MAX : sum[9:0];
    end else begin
      step_x = x;
    end
  endfunction

endpackage

// File: rtl/p09_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
module p09_sync2 (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/p09_paddle_controller.sv
// Paddle x position from left/right buttons, updated once per frame on the first
// non-visible line, with a speed ramp while a direction is held.
module p09_paddle_controller
  import p09_paddle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       enable,
  input  logic       recentre,
  output logic [9:0] x,
  output logic       moving,
  output logic       at_left_edge,
  output logic       at_right_edge
);

  logic   left_s, right_s;
  logic   tick;
  state_e dir;
  state_e state;
  logic [2:0] speed;
  logic [2:0] acc_cnt;
  logic [2:0] step;

  p09_sync2 u_sync_left (
    .clk  (clk),
    .nRst (nRst),
    .d    (btn_left),
    .q    (left_s)
  );

  p09_sync2 u_sync_right (
    .clk  (clk),
    .nRst (nRst),
    .d    (btn_right),
    .q    (right_s)
  );

  assign tick = (hpos == 10'd0) && (vpos == UPDATE_LINE);

  always_comb begin
    dir = StIdle;
    if (left_s && !right_s) begin
      dir = StMoveL;
    end else if (right_s && !left_s) begin
      dir = StMoveR;
    end
  end

  // A fresh move or a reversal always starts at the minimum speed.
  assign step = (dir == state) ? speed : SPEED_MIN;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      x       <= X_RESET;
      state   <= StIdle;
      speed   <= SPEED_MIN;
      acc_cnt <= 3'd0;
    end else if (tick) begin
      if (recentre) begin
        x       <= X_RESET;
        state   <= StIdle;
        speed   <= SPEED_MIN;
        acc_cnt <= 3'd0;
      end else if (!enable || dir == StIdle) begin
        state   <= StIdle;
        speed   <= SPEED_MIN;
        acc_cnt <= 3'd0;
      end else begin
        x <= step_x(x, step, dir);
        if (dir != state) begin
          state   <= dir;
          speed   <= SPEED_MIN;
          acc_cnt <= 3'd1;
        end else if (acc_cnt == ACCEL_FRAMES - 3'd1) begin
          acc_cnt <= 3'd0;
          speed   <= (speed < SPEED_MAX) ? speed + 3'd1 : SPEED_MAX;
        end else begin
          acc_cnt <= acc_cnt + 3'd1;
        end
      end
    end
  end

  assign moving        = (state != StIdle);
  assign at_left_edge  = (x == 10'd0);
  assign at_right_edge = (x == X_MAX);

endmodule

// File: tb/tb_p09_paddle_controller.sv
// Directed bench for p09_paddle_controller: drives frame ticks directly through hpos/vpos
// and compares against hand-computed paddle positions.
module tb_p09_paddle_controller;

  logic       clk = 1'b0;
  logic       nRst;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       btn_left, btn_right, enable, recentre;
  logic [9:0] x;
  logic       moving, at_left_edge, at_right_edge;

  int checks = 0;
  int errors = 0;

  p09_paddle_controller dut (
    .clk           (clk),
    .nRst          (nRst),
    .hpos          (hpos),
    .vpos          (vpos),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .enable        (enable),
    .recentre      (recentre),
    .x             (x),
    .moving        (moving),
    .at_left_edge  (at_left_edge),
    .at_right_edge (at_right_edge)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      hpos = 10'd5;
      vpos = 9'd100;
    end
  endtask

  // One-clock tick; returns on the following negedge so x is sampled after the update.
  task automatic do_tick();
    @(negedge clk);
    hpos = 10'd0;
    vpos = 9'd480;
    @(negedge clk);
    hpos = 10'd5;
    vpos = 9'd100;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      idle_clks(4);
      do_tick();
    end
  endtask

  task automatic set_btn(input logic l, input logic r);
    @(negedge clk);
    btn_left  = l;
    btn_right = r;
  endtask

  logic [9:0] ramp_exp [12] = '{10'd297, 10'd298, 10'd299, 10'd300, 10'd302, 10'd304,
                                10'd306, 10'd308, 10'd311, 10'd314, 10'd317, 10'd320};

  initial begin
    nRst = 1'b0;
    hpos = 10'd5;
    vpos = 9'd100;
    btn_left = 1'b0;
    btn_right = 1'b0;
    enable = 1'b1;
    recentre = 1'b0;
    idle_clks(3);
    check_val("reset_x", 32'(x), 32'd296);
    check_val("reset_moving", 32'(moving), 32'd0);
    check_val("reset_edges", 32'({at_left_edge, at_right_edge}), 32'd0);
    @(negedge clk);
    nRst = 1'b1;

    // 1: idle frames, x stable mid-frame
    for (int f = 0; f < 3; f++) begin
      idle_clks(6);
      check_val("idle_mid_x", 32'(x), 32'd296);
      do_tick();
      check_val("idle_tick_x", 32'(x), 32'd296);
    end
    check_val("idle_moving", 32'(moving), 32'd0);

    // 2: right ramp
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      frames(1);
      check_val($sformatf("ramp_r%0d", i), 32'(x), 32'(ramp_exp[i]));
    end
    check_val("ramp_moving", 32'(moving), 32'd1);
    set_btn(1'b0, 1'b0);
    frames(1);
    check_val("release_x", 32'(x), 32'd320);
    check_val("release_moving", 32'(moving), 32'd0);

    // 3: left to x=5, then to the left edge
    set_btn(1'b1, 1'b0);
    frames(62);
    check_val("long_left_x", 32'(x), 32'd8);
    set_btn(1'b0, 1'b0);
    frames(1);
    set_btn(1'b1, 1'b0);
    frames(3);
    check_val("approach_x", 32'(x), 32'd5);
    set_btn(1'b0, 1'b0);
    frames(1);
    set_btn(1'b1, 1'b0);
    frames(1);
    check_val("left_a", 32'(x), 32'd4);
    frames(1);
    check_val("left_b", 32'(x), 32'd3);
    frames(2);
    check_val("left_c", 32'(x), 32'd1);
    frames(1);
    check_val("left_clamp", 32'(x), 32'd0);
    check_val("left_edge", 32'(at_left_edge), 32'd1);
    frames(2);
    check_val("left_hold", 32'(x), 32'd0);
    check_val("left_hold_moving", 32'(moving), 32'd1);

    // 4: reversal restarts the ramp
    set_btn(1'b0, 1'b0);
    frames(1);
    set_btn(1'b0, 1'b1);
    frames(8);
    check_val("rev_up", 32'(x), 32'd12);
    set_btn(1'b1, 1'b0);
    frames(1);
    check_val("rev_first", 32'(x), 32'd11);
    frames(3);
    check_val("rev_ramp1", 32'(x), 32'd8);
    frames(1);
    check_val("rev_ramp2", 32'(x), 32'd6);

    // disabled: paddle frozen
    enable = 1'b0;
    set_btn(1'b0, 1'b1);
    frames(2);
    check_val("dis_x", 32'(x), 32'd6);
    check_val("dis_moving", 32'(moving), 32'd0);
    enable = 1'b1;

    // 5: both buttons, then a pulse entirely between ticks
    set_btn(1'b1, 1'b1);
    frames(2);
    check_val("both_x", 32'(x), 32'd6);
    check_val("both_moving", 32'(moving), 32'd0);
    set_btn(1'b0, 1'b0);
    set_btn(1'b0, 1'b1);
    idle_clks(100);
    set_btn(1'b0, 1'b0);
    frames(1);
    check_val("pulse_x", 32'(x), 32'd6);
    check_val("pulse_moving", 32'(moving), 32'd0);

    // 6: right edge, recentre priority, async reset mid-move
    set_btn(1'b0, 1'b1);
    frames(110);
    check_val("right_clamp", 32'(x), 32'd592);
    check_val("right_edge", 32'(at_right_edge), 32'd1);
    frames(1);
    check_val("right_hold", 32'(x), 32'd592);
    recentre = 1'b1;
    frames(1);
    recentre = 1'b0;
    check_val("recentre_x", 32'(x), 32'd296);
    check_val("recentre_moving", 32'(moving), 32'd0);
    frames(2);
    check_val("post_rc_x", 32'(x), 32'd298);
    check_val("post_rc_moving", 32'(moving), 32'd1);
    idle_clks(2);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check_val("async_rst_x", 32'(x), 32'd296);
    check_val("async_rst_moving", 32'(moving), 32'd0);
    idle_clks(2);
    nRst = 1'b1;
    set_btn(1'b0, 1'b0);
    frames(1);
    check_val("after_rst_x", 32'(x), 32'd296);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
